load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/load_store_unit_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared ISA constants for the load/store unit: register width, address space,
// access-size and FSM state encodings.
package load_store_unit_pkg;

  localparam int unsigned REG_SIZE        = 32;
  localparam int unsigned ADDRESS_SPACE_W = 32;

  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzIllegal = 2'b11
  } access_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWr,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational little-endian lane extraction with sign/zero extension
// for loads, and lane merge of store data into a read word for read-modify-write.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [REG_SIZE-1:0] i_word,
  input  logic [REG_SIZE-1:0] i_wdata,
  input  logic [1:0]          i_size,
  input  logic [1:0]          i_lane,
  input  logic                i_unsigned,
  output logic [REG_SIZE-1:0] o_load,
  output logic [REG_SIZE-1:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_word[{i_lane[1], 4'b0000} +: 16];
    o_load  = i_word;
    o_merge = i_wdata;
    case (i_size)
      SzByte: begin
        o_load = i_unsigned ? {{(REG_SIZE-8){1'b0}}, w_byte}
                            : {{(REG_SIZE-8){w_byte[7]}}, w_byte};
        o_merge = i_word;
        o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SzHalf: begin
        o_load = i_unsigned ? {{(REG_SIZE-16){1'b0}}, w_half}
                            : {{(REG_SIZE-16){w_half[15]}}, w_half};
        o_merge = i_word;
        o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging a pipeline request to a single-port word memory.
// Byte/half accesses (read-modify-write stores) are built only with LSU_SUBWORD_EN defined.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_SIZE
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [REG_SIZE-1:0] i_req_wdata,
  output logic                o_resp_valid,
  output logic [REG_SIZE-1:0] o_resp_rdata,
  output logic                o_resp_err,
  output logic                o_mem_en,
  output logic                o_mem_rw,
  output logic [REG_SIZE-1:0] o_mem_addr,
  output logic [REG_SIZE-1:0] o_mem_wdata,
  input  logic [REG_SIZE-1:0] i_mem_rdata
);

  lsu_state_e          r_state, w_state_next;
  logic                r_we, r_unsigned, r_err;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [REG_SIZE-1:0] r_wdata, r_word;
  logic                w_accept, w_req_err;
  logic [REG_SIZE-1:0] w_load, w_merge;

  assign w_accept = i_req_valid && (r_state == StIdle);

  always_comb begin
`ifdef LSU_SUBWORD_EN
    case (i_req_size)
      SzByte:  w_req_err = 1'b0;
      SzHalf:  w_req_err = i_req_addr[0];
      SzWord:  w_req_err = |i_req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
`else
    w_req_err = (i_req_size != SzWord) || (|i_req_addr[1:0]);
`endif
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          if (w_req_err) begin
            w_state_next = StResp;
          end else if (i_req_we && (i_req_size == SzWord)) begin
            w_state_next = StWr;
          end else begin
            w_state_next = StRdReq;
          end
        end
      end
      StRdReq:  w_state_next = StRdData;
`ifdef LSU_SUBWORD_EN
      StRdData: w_state_next = r_we ? StWr : StResp;
`else
      StRdData: w_state_next = StResp;
`endif
      StWr:     w_state_next = StResp;
      StResp:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we       <= i_req_we;
        r_unsigned <= i_req_unsigned;
        r_err      <= w_req_err;
        r_size     <= i_req_size;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
      end
      if (r_state == StRdData) begin
        r_word <= i_mem_rdata;
      end
    end
  end

  lsu_lane_align u_lane_align (
    .i_word     (r_word),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // Moore outputs; reset gates the enable so no write can slip out before the state clears.
  always_comb begin
    o_req_ready  = (r_state == StIdle);
    o_resp_valid = (r_state == StResp);
    o_resp_err   = (r_state == StResp) && r_err;
    o_resp_rdata = '0;
    if ((r_state == StResp) && !r_we && !r_err) begin
      o_resp_rdata = w_load;
    end
    o_mem_en    = !i_rst && ((r_state == StRdReq) || (r_state == StWr));
    o_mem_rw    = (r_state == StWr);
    o_mem_addr  = REG_SIZE'(r_addr >> 2);
    o_mem_wdata = (r_state == StWr) ? w_merge : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against
// a byte-level reference model. Honours LSU_SUBWORD_EN the same way as the RTL build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_rw;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_mem_en       (mem_en),
    .o_mem_rw       (mem_rw),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .i_mem_rdata    (mem_rdata)
  );

  // Synchronous single-port memory with registered read data and a backdoor load port.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (mem_en) begin
      if (mem_rw) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = 6'(idx);
    bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Expected outcome from the access rules; applies stores to ref_mem.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic err, output logic [31:0] rd,
                                output int ens);
    logic        legal;
    int          nb, bits, off, idx;
    logic [63:0] mask, v, m;
`ifdef LSU_SUBWORD_EN
    legal = (sz == 2'd0) || (sz == 2'd1 && addr % 2 == 0) || (sz == 2'd2 && addr % 4 == 0);
`else
    legal = (sz == 2'd2) && (addr % 4 == 0);
`endif
    rd  = 32'h0;
    err = !legal;
    if (!legal) begin
      lat = 1;
      ens = 0;
      return;
    end
    nb   = 1 << sz;
    bits = 8 * nb;
    off  = int'(addr % 4);
    idx  = int'(addr / 4);
    mask = (64'd1 << bits) - 64'd1;
    if (!we) begin
      lat = 3;
      ens = 1;
      v = ({32'h0, ref_mem[idx]} >> (8 * off)) & mask;
      if (!uns && v[bits-1]) v = v - (64'd1 << bits);
      rd = v[31:0];
    end else begin
      lat = (nb == 4) ? 2 : 4;
      ens = (nb == 4) ? 1 : 2;
      m = mask << (8 * off);
      v = ({32'h0, ref_mem[idx]} & ~m) | (({32'h0, wd} << (8 * off)) & m);
      ref_mem[idx] = v[31:0];
    end
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int          lat, ens, cyc, en_cnt, idx;
    logic        err, got;
    logic [31:0] rd, g_rdata;
    logic        g_err;
    model(we, sz, uns, addr, wd, lat, err, rd, ens);
    idx = int'(addr / 4);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; cyc = 99; en_cnt = 0; g_rdata = 'x; g_err = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        check_eq({tag, "_maddr"}, mem_addr, addr >> 2);
      end
      if (resp_valid) begin
        got = 1'b1; cyc = c; g_rdata = resp_rdata; g_err = resp_err;
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'(lat));
    check_eq({tag, "_err"}, 32'(g_err), 32'(err));
    check_eq({tag, "_rdata"}, g_rdata, rd);
    check_eq({tag, "_mem_en_cycles"}, 32'(en_cnt), 32'(ens));
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int          lat, ens, cnt, c_resp, c_rdy;
    logic        err;
    logic [31:0] rd, a;
    logic [1:0]  sz;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) bd_write(i, $urandom);

    bd_write(5, 32'hDEADBEEF);
    do_op("ld_word", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    do_op("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0);
    do_op("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
    do_op("st_half", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234);
    do_op("ld_misal", 1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
    do_op("st_illegal", 1'b1, 2'b11, 1'b0, 32'h18, 32'h55);

    // Reset asserted while the word store sits in WR.
    bd_write(3, 32'h11111111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0C;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rstwr_in_wr", 32'(mem_rw), 32'd1);
    rst = 1'b1;
    #1 check_eq("rstwr_en_forced", 32'(mem_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check_eq("rstwr_no_resp", 32'(cnt), 32'd0);
    check_eq("rstwr_ready", 32'(req_ready), 32'd1);
    check_eq("rstwr_mem", mem[3], 32'h11111111);

    // Two word stores with req_valid held high throughout.
    model(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE0001, lat, err, rd, ens);
    model(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFE0002, lat, err, rd, ens);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20;
    req_wdata = 32'hCAFE0001;
    @(posedge clk);
    #1 req_addr = 32'h24; req_wdata = 32'hCAFE0002;
    c_resp = 0; c_rdy = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid && c_resp == 0) c_resp = c;
      if (req_ready) begin
        c_rdy = c;
        break;
      end
    end
    check_eq("b2b_first_resp", 32'(c_resp), 32'd2);
    check_eq("b2b_second_accept", 32'(c_rdy), 32'd3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cnt = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        cnt = c;
        break;
      end
    end
    check_eq("b2b_second_lat", 32'(cnt), 32'd2);
    @(posedge clk);
    #1;
    check_eq("b2b_mem_a", mem[8], ref_mem[8]);
    check_eq("b2b_mem_b", mem[9], ref_mem[9]);

    for (int i = 0; i < 250; i++) begin
      a  = 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        sz = 2'b10;
        a  = a & 32'hFC;
      end
      do_op("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
